// File: rtl/ifetch_pkg.sv
// ifetch_pkg: shared constants, prefetch-queue entry type and count-width helper.
package ifetch_pkg;
    localparam int INST_BYTES = 4;
    localparam int IF_XLEN    = 32;
    localparam int IF_ILEN    = 32;

    typedef struct packed {
        logic               fault;
        logic [IF_XLEN-1:0] pc;
        logic [IF_ILEN-1:0] inst;
    } fetch_entry_t;

    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction
endpackage

// File: rtl/ifetch_queue_fifo.sv
// fetch_fifo: synchronous DEPTH-entry FIFO of fetch entries with flush; empty head reads as zero.
module fetch_fifo
    import ifetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        flush_i,
    input  logic                        push_i,
    input  fetch_entry_t                push_data_i,
    input  logic                        pop_i,
    output fetch_entry_t                pop_data_o,
    output logic                        full_o,
    output logic                        empty_o,
    output logic [cnt_width(DEPTH)-1:0] count_o
);
    localparam int CW = cnt_width(DEPTH);
    localparam int AW = $clog2(DEPTH);

    fetch_entry_t  mem_q [DEPTH];
    logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          do_push, do_pop;

    assign full_o     = cnt_q == CW'(DEPTH);
    assign empty_o    = cnt_q == '0;
    assign count_o    = cnt_q;
    assign do_push    = push_i && !full_o && !flush_i;
    assign do_pop     = pop_i && !empty_o && !flush_i;
    assign pop_data_o = empty_o ? '0 : mem_q[rd_q];

    always_comb begin
        rd_d  = flush_i ? '0 : rd_q + AW'(do_pop);
        wr_d  = flush_i ? '0 : wr_q + AW'(do_push);
        cnt_d = flush_i ? '0 : cnt_q + CW'(do_push) - CW'(do_pop);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
        end
    end

    // Storage needs no reset: the empty head is masked to zero.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= push_data_i;
    end
endmodule

// File: rtl/ifetch_queue.sv
// ifetch_queue: instruction fetch with credit-bounded requests, redirect/discard and a prefetch queue.
// IFETCH_ALIGN_CHECK_EN enables the misaligned-redirect halt and fault entry.
module ifetch_queue
    import ifetch_pkg::*;
#(
    parameter int              XLEN     = IF_XLEN,
    parameter int              ILEN     = IF_ILEN,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect_valid_i,
    input  logic [XLEN-1:0] redirect_addr_i,
    output logic            imem_req_valid_o,
    input  logic            imem_req_ready_i,
    output logic [XLEN-1:0] imem_req_addr_o,
    input  logic            imem_rsp_valid_i,
    input  logic [ILEN-1:0] imem_rsp_data_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [ILEN-1:0] out_inst_o,
    output logic [XLEN-1:0] out_pc_o,
    output logic            out_fault_o
);
    localparam int              CW    = cnt_width(DEPTH);
    localparam logic [CW:0]     LIMIT = (CW+1)'(DEPTH);
    localparam logic [XLEN-1:0] STEP  = XLEN'(INST_BYTES);

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d, rsp_pc_q, rsp_pc_d, redir_pc;
    logic [CW-1:0]   inflight_q, inflight_d, discard_q, discard_d, occ;
    logic            halted_q, fault_push, req_fire, rsp_keep, q_empty, q_full;
    fetch_entry_t    push_data, head;

`ifdef IFETCH_ALIGN_CHECK_EN
    logic halted_d, fault_pend_q, fault_pend_d, redir_bad;
    logic unused_full;
    assign unused_full = q_full;
    assign redir_pc    = redirect_addr_i;
    assign redir_bad   = redirect_addr_i[1:0] != 2'b00;
    // All in-flight fetches are being discarded while halted, so the fault entry waits for them.
    assign fault_push  = fault_pend_q && discard_q == '0 && !redirect_valid_i;
    assign out_fault_o = head.fault;

    always_comb begin
        halted_d     = redirect_valid_i ? redir_bad : halted_q;
        fault_pend_d = redirect_valid_i ? redir_bad : fault_pend_q && !fault_push;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            halted_q     <= 1'b0;
            fault_pend_q <= 1'b0;
        end else begin
            halted_q     <= halted_d;
            fault_pend_q <= fault_pend_d;
        end
    end
`else
    logic unused_bits;
    assign unused_bits = ^{head.fault, redirect_addr_i[1:0], q_full};
    assign redir_pc    = {redirect_addr_i[XLEN-1:2], 2'b00};
    assign halted_q    = 1'b0;
    assign fault_push  = 1'b0;
    assign out_fault_o = 1'b0;
`endif

    assign imem_req_addr_o  = fetch_pc_q;
    assign imem_req_valid_o = !redirect_valid_i && !halted_q && ({1'b0, occ} + {1'b0, inflight_q} < LIMIT);
    assign req_fire         = imem_req_valid_o && imem_req_ready_i;
    assign rsp_keep         = imem_rsp_valid_i && discard_q == '0 && !redirect_valid_i;
    assign out_valid_o      = !q_empty;
    assign out_inst_o       = head.inst;
    assign out_pc_o         = head.pc;

    always_comb begin
        fetch_pc_d     = redirect_valid_i ? redir_pc : fetch_pc_q + (req_fire ? STEP : '0);
        rsp_pc_d       = redirect_valid_i ? redir_pc : rsp_pc_q + (rsp_keep ? STEP : '0);
        inflight_d     = inflight_q + CW'(req_fire) - CW'(imem_rsp_valid_i);
        discard_d      = redirect_valid_i ? inflight_q - CW'(imem_rsp_valid_i)
                                          : discard_q - CW'(imem_rsp_valid_i && discard_q != '0);
        push_data.fault = fault_push;
        push_data.pc    = fault_push ? fetch_pc_q : rsp_pc_q;
        push_data.inst  = fault_push ? '0 : imem_rsp_data_i;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc_q <= RESET_PC;
            rsp_pc_q   <= RESET_PC;
            inflight_q <= '0;
            discard_q  <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            rsp_pc_q   <= rsp_pc_d;
            inflight_q <= inflight_d;
            discard_q  <= discard_d;
        end
    end

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (redirect_valid_i),
        .push_i      (rsp_keep || fault_push),
        .push_data_i (push_data),
        .pop_i       (out_ready_i),
        .pop_data_o  (head),
        .full_o      (q_full),
        .empty_o     (q_empty),
        .count_o     (occ)
    );
endmodule

// File: tb/tb_ifetch_queue.sv
// tb_ifetch_queue: randomized fetch/redirect traffic against a queue-based reference model.
module tb_ifetch_queue;
    localparam int XLEN  = 32;
    localparam int ILEN  = 32;
    localparam int DEPTH = 4;
`ifdef IFETCH_ALIGN_CHECK_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            redirect_valid = 1'b0;
    logic [XLEN-1:0] redirect_addr = '0;
    logic            imem_req_valid, imem_req_ready = 1'b0;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_rsp_valid = 1'b0;
    logic [ILEN-1:0] imem_rsp_data = '0;
    logic            out_valid, out_ready = 1'b0, out_fault;
    logic [ILEN-1:0] out_inst;
    logic [XLEN-1:0] out_pc;

    always #5 clk = ~clk;

    ifetch_queue #(.XLEN(XLEN), .ILEN(ILEN), .DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
        .clk              (clk),
        .rst              (rst),
        .redirect_valid_i (redirect_valid),
        .redirect_addr_i  (redirect_addr),
        .imem_req_valid_o (imem_req_valid),
        .imem_req_ready_i (imem_req_ready),
        .imem_req_addr_o  (imem_req_addr),
        .imem_rsp_valid_i (imem_rsp_valid),
        .imem_rsp_data_i  (imem_rsp_data),
        .out_valid_o      (out_valid),
        .out_ready_i      (out_ready),
        .out_inst_o       (out_inst),
        .out_pc_o         (out_pc),
        .out_fault_o      (out_fault)
    );

    typedef struct { logic [31:0] pc; logic [31:0] inst; logic fault; } ent_t;
    typedef struct { logic [31:0] addr; int due; } req_t;

    ent_t        mq[$];
    req_t        memq[$];
    logic [31:0] m_fetch, m_rsp;
    int          m_infl, m_disc, cyc;
    bit          m_halt, m_fpend;
    int          p_redir, p_rdy, p_ordy, lat_min, lat_max;
    int          n_checks = 0, n_fail = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] memfn(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [31:0] pick_addr();
        logic [31:0] r;
        int k;
        r = $urandom;
        k = $urandom_range(3);
        return k == 0 ? r : k == 1 ? (32'hFFFF_FFF0 | (r & 32'hF)) : k == 2 ? (r & 32'h3FC) : (r & 32'hFFF);
    endfunction

    // mode 0: random redirect; mode 1: forced redirect to fa
    task automatic step(input int mode = 0, input logic [31:0] fa = 32'h0);
        bit rv, mr, orr, mv, fire, exp_rv;
        logic [31:0] ra, a, rdata;
        int due;
        rv  = mode == 1 || (mode == 0 && $urandom_range(999) < p_redir);
        ra  = mode == 1 ? fa : pick_addr();
        mr  = $urandom_range(99) < p_rdy;
        orr = $urandom_range(99) < p_ordy;
        mv  = memq.size() > 0 && memq[0].due <= cyc;
        rdata = mv ? memfn(memq[0].addr) : $urandom;
        redirect_valid = rv;
        redirect_addr  = ra;
        imem_req_ready = mr;
        out_ready      = orr;
        imem_rsp_valid = mv;
        imem_rsp_data  = rdata;
        #1;
        exp_rv = !rv && !m_halt && (mq.size() + m_infl < DEPTH);
        check("req_valid", imem_req_valid, exp_rv);
        if (exp_rv) check("req_addr", imem_req_addr, m_fetch);
        check("out_valid", out_valid, mq.size() > 0);
        if (mq.size() > 0) begin
            check("out_pc", out_pc, mq[0].pc);
            check("out_inst", out_inst, mq[0].inst);
            check("out_fault", out_fault, mq[0].fault);
        end
        fire = exp_rv && mr;
        if (mv) void'(memq.pop_front());
        if (fire) begin
            due = cyc + $urandom_range(lat_max, lat_min);
            if (memq.size() > 0 && due <= memq[$].due) due = memq[$].due + 1;
            memq.push_back('{m_fetch, due});
        end
        if (rv) begin
            a = ALIGN ? ra : {ra[31:2], 2'b00};
            m_disc = m_infl - int'(mv);
            m_infl = m_disc;
            mq.delete();
            m_fetch = a;
            m_rsp = a;
            m_halt = ALIGN && a[1:0] != 2'b00;
            m_fpend = m_halt;
        end else begin
            if (mq.size() > 0 && orr) void'(mq.pop_front());
            if (mv) begin
                m_infl--;
                if (m_disc > 0) m_disc--;
                else begin
                    mq.push_back('{m_rsp, rdata, 1'b0});
                    m_rsp += 4;
                end
            end else if (m_fpend && m_disc == 0) begin
                mq.push_back('{m_fetch, 32'h0, 1'b1});
                m_fpend = 0;
            end
            if (fire) begin
                m_fetch += 4;
                m_infl++;
            end
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Asynchronous reset asserted mid-cycle; out_* must clear before any clock edge.
    task automatic do_reset();
        #2 rst = 1'b0;
        redirect_valid = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        out_ready = 1'b0;
        #1;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_pc", out_pc, 32'h0);
        check("rst_out_inst", out_inst, 32'h0);
        check("rst_out_fault", out_fault, 1'b0);
        mq.delete();
        memq.delete();
        m_fetch = 32'h0;
        m_rsp = 32'h0;
        m_infl = 0;
        m_disc = 0;
        m_halt = 0;
        m_fpend = 0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic knobs(input int pr, input int rdy, input int ordy, input int lmin, input int lmax);
        p_redir = pr;
        p_rdy = rdy;
        p_ordy = ordy;
        lat_min = lmin;
        lat_max = lmax;
    endtask

    initial begin
        cyc = 0;
        knobs(0, 100, 100, 1, 1);
        @(negedge clk);
        do_reset();
        run(20);
        knobs(0, 100, 0, 1, 1);
        run(12);
        knobs(0, 100, 100, 1, 1);
        run(10);
        knobs(0, 100, 100, 3, 3);
        run(2);
        step(1, 32'h100);
        run(12);
        step(1, 32'hFFFF_FFF4);
        run(10);
        step(1, 32'h102);
        run(8);
        step(1, 32'h200);
        run(8);
        knobs(30, 70, 70, 1, 4);
        run(3000);
        do_reset();
        knobs(60, 50, 40, 1, 6);
        run(2000);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
